spi_fl_seq: RTL and testbench
=============================

SPI_FL_SEQ -- requirements
Module: spi_fl_seq

Interface
REQ-001 SHALL have parameter WREN_CMD, default 8'h06, write-enable opcode issued before program/erase.
REQ-002 SHALL have parameter RDSR_CMD, default 8'h05, read-status opcode used for busy polling.
REQ-003 SHALL have parameter POLL_MAX, default 16'd4096, maximum RDSR polls before timeout (used only when timeout is compiled in).
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: req_valid  in  1  request strobe; req_ready  out  1  sequencer idle, accepts request.
REQ-006 SHALL have ports: req_op  in  2  00 raw, 01 program, 10 erase, 11 reserved (treated as raw).
REQ-007 SHALL have ports: req_command  in  8; req_commtype  in  3; req_address  in  32; req_data  in  32; req_nmiso_bits  in  7.
REQ-008 SHALL have ports: rsp_valid  out  1  one-cycle completion pulse; rsp_data  out  32  raw-op read data; rsp_error  out  1  poll timeout.
REQ-009 SHALL have master-side ports: m_validflag  out  1; m_command  out  8; m_commtype  out  3; m_address  out  32; m_data_in  out  32; m_nmiso_bits  out  7.
REQ-010 SHALL have master-side ports: m_tready  in  1  master idle; m_data_out  in  32  master read data.

Function
REQ-011 SHALL implement states IDLE, WREN, OP, POLL, DONE; each of WREN/OP/POLL has sub-phases ISSUE and WAIT.
REQ-012 req_ready SHALL be 1 only in IDLE; request captured into internal registers when req_valid && req_ready.
REQ-013 Transitions: IDLE->OP (raw/reserved), IDLE->WREN (program/erase); WREN->OP; OP->POLL (program/erase) or OP->DONE (raw); POLL->POLL (WIP=1) or DONE (WIP=0); DONE->IDLE after one cycle.
REQ-014 ISSUE: drive m_* fields, m_validflag=1; hold until m_tready sampled 0 (accepted), then m_validflag=0, enter WAIT.
REQ-015 WAIT: stay until m_tready sampled 1 (transfer complete); m_data_out sampled that same cycle.
REQ-016 m_validflag SHALL be low for at least one cycle between consecutive transfers.
REQ-017 WREN transfer: command=WREN_CMD, commtype=3'b000, address/data 0.
REQ-018 OP transfer: captured request fields passed unmodified.
REQ-019 POLL transfer: command=RDSR_CMD, commtype=3'b001, nmiso_bits=7'd8; WIP = m_data_out[7].
REQ-020 rsp_valid SHALL pulse exactly one cycle in DONE; rsp_data = OP read data for raw ops, 0 otherwise; held until next DONE.
REQ-021 Requests arriving while not IDLE SHALL be ignored (not queued); req_valid in DONE cycle ignored.
REQ-022 m_tready already 0 at ISSUE entry SHALL NOT count as acceptance; acceptance requires a 1->0 after m_validflag rises.

Reset
REQ-023 On rst_n=0 (async): state IDLE, req_ready=1, m_validflag=0, all m_* fields 0, rsp_valid=0, rsp_data=0, rsp_error=0, poll counter 0.
REQ-024 Reset mid-transfer SHALL abort immediately with no rsp_valid; master recovery is the master's own reset.

Configuration
REQ-025 Macro SPI_FL_SEQ_POLL_TIMEOUT_EN defined: 16-bit poll counter, cleared on POLL entry; after POLL_MAX polls with WIP=1, go DONE with rsp_error=1.
REQ-026 Macro undefined: no counter, polling unbounded, rsp_error tied 0.

Structure
REQ-027 Shared package spi_fl_pkg SHALL hold op encodings, commtype codes (000..101), state encodings, default opcodes.
REQ-028 No sub-module; single FSM plus capture registers; instantiated alongside spi_master_fl.

Verification
REQ-029 Raw read: op=00, cmd 8'h9F, commtype 001, nmiso 24, model returns 24'hEF4018 -> one transfer, rsp_data=32'h00EF4018 (bit placement per master), rsp_error=0.
REQ-030 Program: op=01, cmd 8'h02, addr 24'h000100, data 32'hA5A5A5A5, WIP=1 for 3 polls -> transfers 06, 02, 05x4; one rsp_valid.
REQ-031 Erase with WIP=0 at first poll -> exactly 3 transfers (06, 20, 05), rsp_valid one cycle later.
REQ-032 Timeout (macro on, POLL_MAX=4, WIP stuck 1) -> 4 polls, rsp_error=1; macro off -> polls continue past 4.
REQ-033 req_valid pulsed during OP -> ignored, no extra transfer; req_ready=0 throughout.
REQ-034 rst_n low during POLL WAIT -> all outputs reset values same cycle, no rsp_valid, next request proceeds normally.

Source files
------------

// File: rtl/spi_fl_pkg.sv
// Shared types for the SPI flash sequencer: op/commtype encodings, FSM states,
// default flash opcodes and the transfer payload handed to spi_master_fl.
package spi_fl_pkg;

  localparam int unsigned CMD_W   = 8;
  localparam int unsigned CT_W    = 3;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NMISO_W = 7;

  localparam logic [CMD_W-1:0]   DEF_WREN_CMD = 8'h06;
  localparam logic [CMD_W-1:0]   DEF_RDSR_CMD = 8'h05;
  localparam logic [NMISO_W-1:0] RDSR_NMISO   = 7'd8;

  typedef enum logic [1:0] {
    OP_RAW     = 2'b00,
    OP_PROGRAM = 2'b01,
    OP_ERASE   = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [CT_W-1:0] {
    CT_CMD     = 3'b000,
    CT_CMD_RD  = 3'b001,
    CT_CMD_WR  = 3'b010,
    CT_ADDR    = 3'b011,
    CT_ADDR_RD = 3'b100,
    CT_ADDR_WR = 3'b101
  } commtype_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREN,
    ST_OP,
    ST_POLL,
    ST_DONE
  } state_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

  typedef struct packed {
    logic [CMD_W-1:0]   command;
    logic [CT_W-1:0]    commtype;
    logic [ADDR_W-1:0]  address;
    logic [DATA_W-1:0]  data;
    logic [NMISO_W-1:0] nmiso;
  } xfer_t;

  // Program and erase need the write-enable preamble and busy polling.
  function automatic logic needs_wren(input logic [1:0] op);
    return (op == OP_PROGRAM) || (op == OP_ERASE);
  endfunction

  function automatic xfer_t ctl_xfer(input logic [CMD_W-1:0] cmd,
                                     input logic [CT_W-1:0] ct,
                                     input logic [NMISO_W-1:0] nm);
    xfer_t x;
    x          = '0;
    x.command  = cmd;
    x.commtype = ct;
    x.nmiso    = nm;
    return x;
  endfunction

endpackage

// File: rtl/spi_fl_seq.sv
// SPI flash op sequencer: raw ops pass through; program/erase get WREN + RDSR polling.
// Optional poll timeout compiled in with `define SPI_FL_SEQ_POLL_TIMEOUT_EN.
module spi_fl_seq
  import spi_fl_pkg::*;
#(
  parameter logic [CMD_W-1:0] WREN_CMD = DEF_WREN_CMD,
  parameter logic [CMD_W-1:0] RDSR_CMD = DEF_RDSR_CMD,
  parameter logic [15:0]      POLL_MAX = 16'd4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [CMD_W-1:0]     req_command,
  input  logic [CT_W-1:0]      req_commtype,
  input  logic [ADDR_W-1:0]    req_address,
  input  logic [DATA_W-1:0]    req_data,
  input  logic [NMISO_W-1:0]   req_nmiso_bits,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_error,
  output logic                 m_validflag,
  output logic [CMD_W-1:0]     m_command,
  output logic [CT_W-1:0]      m_commtype,
  output logic [ADDR_W-1:0]    m_address,
  output logic [DATA_W-1:0]    m_data_in,
  output logic [NMISO_W-1:0]   m_nmiso_bits,
  input  logic                 m_tready,
  input  logic [DATA_W-1:0]    m_data_out
);

  state_e             r_state;
  phase_e             r_phase;
  logic               r_seen_hi;
  logic               r_flash;
  xfer_t              r_req;
  xfer_t              r_xfer;
  logic               r_vld;
  logic               r_ready;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;

  logic w_accept;
  logic w_done;
  logic w_wip;
  logic w_poll_done;
  logic w_poll_expired;

  // Acceptance needs tready seen high while validflag is up, then a drop.
  assign w_accept    = r_vld && (r_phase == PH_ISSUE) && r_seen_hi && !m_tready;
  assign w_done      = (r_phase == PH_WAIT) && m_tready;
  assign w_wip       = m_data_out[7];
  assign w_poll_done = (r_state == ST_POLL) && w_done;

`ifdef SPI_FL_SEQ_POLL_TIMEOUT_EN
  logic [15:0] r_poll_cnt;
  logic        r_rsp_error;
  logic        w_poll_entry;

  assign w_poll_entry   = (r_state == ST_OP) && w_done && r_flash;
  assign w_poll_expired = (17'(r_poll_cnt) + 17'd1) >= 17'(POLL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll_cnt  <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      if (w_poll_entry)
        r_poll_cnt <= '0;
      else if (w_poll_done && w_wip)
        r_poll_cnt <= r_poll_cnt + 16'd1;
      if ((r_state == ST_OP) && w_done && !r_flash)
        r_rsp_error <= 1'b0;
      else if (w_poll_done && !(w_wip && !w_poll_expired))
        r_rsp_error <= w_wip;
    end
  end

  assign rsp_error = r_rsp_error;
`else
  logic w_unused_cfg;

  assign w_unused_cfg   = ^POLL_MAX;
  assign w_poll_expired = 1'b0;
  assign rsp_error      = 1'b0;
`endif

  // Main sequencer: state, transfer phase, master fields and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_phase     <= PH_ISSUE;
      r_seen_hi   <= 1'b0;
      r_flash     <= 1'b0;
      r_req       <= '0;
      r_xfer      <= '0;
      r_vld       <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_vld && (r_phase == PH_ISSUE) && m_tready)
        r_seen_hi <= 1'b1;
      if (w_accept) begin
        r_vld   <= 1'b0;
        r_phase <= PH_WAIT;
      end

      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_ready) begin
            r_ready   <= 1'b0;
            r_flash   <= needs_wren(req_op);
            r_req     <= xfer_t'{command: req_command, commtype: req_commtype,
                                 address: req_address, data: req_data,
                                 nmiso: req_nmiso_bits};
            r_vld     <= 1'b1;
            r_phase   <= PH_ISSUE;
            r_seen_hi <= 1'b0;
            if (needs_wren(req_op)) begin
              r_state <= ST_WREN;
              r_xfer  <= ctl_xfer(WREN_CMD, CT_CMD, 7'd0);
            end else begin
              r_state <= ST_OP;
              r_xfer  <= xfer_t'{command: req_command, commtype: req_commtype,
                                 address: req_address, data: req_data,
                                 nmiso: req_nmiso_bits};
            end
          end
        end
        ST_WREN: begin
          if (w_done) begin
            r_state   <= ST_OP;
            r_xfer    <= r_req;
            r_vld     <= 1'b1;
            r_phase   <= PH_ISSUE;
            r_seen_hi <= 1'b0;
          end
        end
        ST_OP: begin
          if (w_done) begin
            if (r_flash) begin
              r_state   <= ST_POLL;
              r_xfer    <= ctl_xfer(RDSR_CMD, CT_CMD_RD, RDSR_NMISO);
              r_vld     <= 1'b1;
              r_phase   <= PH_ISSUE;
              r_seen_hi <= 1'b0;
            end else begin
              r_state     <= ST_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= m_data_out;
            end
          end
        end
        ST_POLL: begin
          if (w_done) begin
            if (w_wip && !w_poll_expired) begin
              r_vld     <= 1'b1;
              r_phase   <= PH_ISSUE;
              r_seen_hi <= 1'b0;
            end else begin
              r_state     <= ST_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = r_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign m_validflag  = r_vld;
  assign m_command    = r_xfer.command;
  assign m_commtype   = r_xfer.commtype;
  assign m_address    = r_xfer.address;
  assign m_data_in    = r_xfer.data;
  assign m_nmiso_bits = r_xfer.nmiso;

endmodule

// File: tb/tb_spi_fl_seq.sv
// Scoreboard bench for spi_fl_seq: behavioural SPI master, transfer and response
// expectations produced from the op rules, compared by independent monitors.
module tb_spi_fl_seq;

  localparam logic [15:0] TB_POLL_MAX = 16'd4;
`ifdef SPI_FL_SEQ_POLL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  cmd;
    logic [2:0]  ct;
    logic [31:0] addr;
    logic [31:0] data;
    logic [6:0]  nm;
  } xf_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_command;
  logic [2:0]  req_commtype;
  logic [31:0] req_address;
  logic [31:0] req_data;
  logic [6:0]  req_nmiso_bits;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        m_validflag;
  logic [7:0]  m_command;
  logic [2:0]  m_commtype;
  logic [31:0] m_address;
  logic [31:0] m_data_in;
  logic [6:0]  m_nmiso_bits;
  logic        m_tready;
  logic [31:0] m_data_out;

  xf_t         exp_xf[$];
  logic [32:0] exp_rsp[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          wip_left = 0;
  logic [31:0] raw_resp = '0;
  bit          stale_en = 1'b1;
  bit          long_lat = 1'b0;
  bit          poll_seen = 1'b0;

  spi_fl_seq #(
    .WREN_CMD(8'h06),
    .RDSR_CMD(8'h05),
    .POLL_MAX(TB_POLL_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_command(req_command), .req_commtype(req_commtype),
    .req_address(req_address), .req_data(req_data),
    .req_nmiso_bits(req_nmiso_bits),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .m_validflag(m_validflag), .m_command(m_command), .m_commtype(m_commtype),
    .m_address(m_address), .m_data_in(m_data_in), .m_nmiso_bits(m_nmiso_bits),
    .m_tready(m_tready), .m_data_out(m_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected transfers and response for one request, straight from the op rules.
  task automatic expect_req(input logic [1:0] op, input xf_t req, input int wip_n,
                            input logic [31:0] rraw);
    bit flash;
    int polls;
    bit to;
    flash = (op == 2'b01) || (op == 2'b10);
    if (flash) exp_xf.push_back(xf_t'{cmd: 8'h06, ct: 3'b000, addr: 32'h0, data: 32'h0, nm: 7'd0});
    exp_xf.push_back(req);
    if (flash) begin
      if (TO_EN && wip_n >= int'(TB_POLL_MAX)) begin
        polls = int'(TB_POLL_MAX);
        to    = 1'b1;
      end else begin
        polls = wip_n + 1;
        to    = 1'b0;
      end
      repeat (polls) exp_xf.push_back(xf_t'{cmd: 8'h05, ct: 3'b001, addr: 32'h0, data: 32'h0, nm: 7'd8});
      exp_rsp.push_back({32'h0, to});
    end else begin
      exp_rsp.push_back({rraw, 1'b0});
    end
  endtask

  // Behavioural master: accepts a transfer by dropping tready, completes by raising it.
  initial begin
    xf_t         got;
    xf_t         e;
    logic [31:0] resp;
    bit          abort;
    int          lat;
    int          d;
    m_tready   = 1'b1;
    m_data_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_tready = 1'b1;
        continue;
      end
      if (!m_validflag) continue;
      abort = 1'b0;
      d = $urandom_range(1, 3);
      for (int k = 0; k < d && !abort; k++) begin
        @(negedge clk);
        if (!rst_n) abort = 1'b1;
      end
      if (abort) begin
        m_tready = 1'b1;
        continue;
      end
      got = xf_t'{cmd: m_command, ct: m_commtype, addr: m_address, data: m_data_in, nm: m_nmiso_bits};
      if (exp_xf.size() == 0) begin
        n_checks++;
        $display("FAIL xfer_extra: got transfer %0h while none expected", got);
      end else begin
        e = exp_xf.pop_front();
        check("xfer", 128'(got), 128'(e));
      end
      m_tready = 1'b0;
      if (got.cmd == 8'h05 && got.ct == 3'b001) begin
        poll_seen = 1'b1;
        resp = $urandom;
        resp[7] = (wip_left > 0);
        if (wip_left > 0) wip_left--;
      end else begin
        resp = raw_resp;
      end
      lat = long_lat ? 6 : $urandom_range(1, 4);
      for (int k = 0; k < lat && !abort; k++) begin
        @(negedge clk);
        if (!rst_n) abort = 1'b1;
      end
      m_tready = 1'b1;
      if (abort) continue;
      m_data_out = resp;
      if (stale_en && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        m_tready = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        m_tready = 1'b1;
      end
    end
  end

  // Response monitor: every rsp_valid cycle must match the oldest expected response.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          n_checks++;
          $display("FAIL rsp_extra: got data %0h err %0b while none expected", rsp_data, rsp_error);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp", 128'({rsp_data, rsp_error}), 128'(e));
        end
      end
    end
  end

  task automatic garbage_pulse();
    req_valid      = 1'b1;
    req_op         = 2'($urandom);
    req_command    = 8'($urandom);
    req_commtype   = 3'($urandom_range(0, 5));
    req_address    = $urandom;
    req_data       = $urandom;
    req_nmiso_bits = 7'($urandom);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [7:0] cmd, input logic [2:0] ct,
                        input logic [31:0] addr, input logic [31:0] data, input logic [6:0] nm,
                        input int wip_n, input logic [31:0] rraw, input bit stray);
    int  t;
    bit  done;
    xf_t req;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_idle", 128'(req_ready), 128'(1));
    req = xf_t'{cmd: cmd, ct: ct, addr: addr, data: data, nm: nm};
    wip_left = wip_n;
    raw_resp = rraw;
    expect_req(op, req, wip_n, rraw);
    req_valid      = 1'b1;
    req_op         = op;
    req_command    = cmd;
    req_commtype   = ct;
    req_address    = addr;
    req_data       = data;
    req_nmiso_bits = nm;
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_busy", 128'(req_ready), 128'(0));
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (rsp_valid) begin
        done = 1'b1;
        if (stray) garbage_pulse();
      end else if (stray && $urandom_range(0, 3) == 0) begin
        check("req_ready_stray", 128'(req_ready), 128'(0));
        garbage_pulse();
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL rsp_timeout: got no rsp_valid within 600 cycles, required one");
    end
    check("req_ready_after", 128'(req_ready), 128'(1));
    check("xfers_left", 128'(exp_xf.size()), 128'(0));
    check("rsps_left", 128'(exp_rsp.size()), 128'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'(1));
    check({tag, "_validflag"}, 128'(m_validflag), 128'(0));
    check({tag, "_m_fields"}, 128'({m_command, m_commtype, m_address, m_data_in, m_nmiso_bits}), 128'(0));
    check({tag, "_rsp"}, 128'({rsp_valid, rsp_data, rsp_error}), 128'(0));
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] cmd;
    int         t;
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_op         = '0;
    req_command    = '0;
    req_commtype   = '0;
    req_address    = '0;
    req_data       = '0;
    req_nmiso_bits = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_req(2'b00, 8'h9F, 3'b001, 32'h0, 32'h0, 7'd24, 0, 32'h00EF4018, 1'b0);
    do_req(2'b01, 8'h02, 3'b101, 32'h00000100, 32'hA5A5A5A5, 7'd0, 3, 32'h1234, 1'b0);
    do_req(2'b10, 8'h20, 3'b011, 32'h00001000, 32'h0, 7'd0, 0, 32'h0, 1'b1);
    do_req(2'b01, 8'h02, 3'b101, 32'h00000200, 32'h5A5A5A5A, 7'd0, 6, 32'h0, 1'b1);
    do_req(2'b01, 8'h02, 3'b101, 32'h00000300, 32'h0F0F0F0F, 7'd0, 4, 32'h0, 1'b0);
    do_req(2'b11, 8'h4B, 3'b100, 32'h00ABCDEF, 32'h0, 7'd64, 0, 32'hCAFEF00D, 1'b1);

    for (int i = 0; i < 25; i++) begin
      op  = 2'($urandom);
      cmd = 8'($urandom);
      if (cmd == 8'h05) cmd = 8'h9F;
      do_req(op, cmd, 3'($urandom_range(0, 5)), $urandom, $urandom, 7'($urandom),
             $urandom_range(0, 6), $urandom, 1'b1);
    end

    // Reset while an RDSR poll is waiting for completion.
    stale_en  = 1'b0;
    long_lat  = 1'b1;
    poll_seen = 1'b0;
    wip_left  = 10;
    exp_xf.push_back(xf_t'{cmd: 8'h06, ct: 3'b000, addr: 32'h0, data: 32'h0, nm: 7'd0});
    exp_xf.push_back(xf_t'{cmd: 8'h02, ct: 3'b101, addr: 32'h40, data: 32'h11223344, nm: 7'd0});
    exp_xf.push_back(xf_t'{cmd: 8'h05, ct: 3'b001, addr: 32'h0, data: 32'h0, nm: 7'd8});
    req_valid      = 1'b1;
    req_op         = 2'b01;
    req_command    = 8'h02;
    req_commtype   = 3'b101;
    req_address    = 32'h40;
    req_data       = 32'h11223344;
    req_nmiso_bits = 7'd0;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!poll_seen && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("poll_reached", 128'(poll_seen), 128'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    check_reset_outputs("heldreset");
    check("midreset_xfers", 128'(exp_xf.size()), 128'(0));
    exp_xf.delete();
    rst_n    = 1'b1;
    long_lat = 1'b0;
    stale_en = 1'b1;
    @(negedge clk);
    do_req(2'b00, 8'h9F, 3'b001, 32'h0, 32'h0, 7'd24, 0, 32'h00C22817, 1'b0);
    do_req(2'b10, 8'hD8, 3'b011, 32'h00020000, 32'h0, 7'd0, 1, 32'h0, 1'b0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
